pingpong_wr_ctrl: RTL and testbench
===================================

// Module: pingpong_wr_ctrl
// PURPOSE
//   Write-side datapath controller for the two-bank circular (ping-pong) buffer.
//   Takes the 2-bit state of the buffer FSM and a sample stream, and generates bank write strobes/addresses.
//   Tracks per-bank full flags against a reader, and returns to the FSM its write-done (t3) and
//   opposite-bank-free (t4) conditions.
// PARAMETERS
//   AW  10  bank address width; max bank length 2**AW samples
//   DW  16  sample width
// PORTS
//   clk          in   1     clock; all logic on posedge
//   rst_n        in   1     asynchronous, active-low reset
//   state        in   2     buffer FSM state: 0 IDLE, 1 READY, 2 WORK, 3 WAIT
//   len          in   AW    samples per bank minus 1; latched, see below
//   din          in   DW    sample
//   din_valid    in   1     sample strobe
//   rd_done      in   1     1-cycle pulse: reader finished bank rd_bank
//   wr_en        out  1     registered RAM write strobe
//   wr_addr      out  AW+1  {bank, offset}
//   wr_data      out  DW    registered din
//   wr_bank      out  1     bank currently being written
//   rd_bank      out  1     oldest full bank, next for reader
//   full         out  2     per-bank full flags
//   bank_done    out  1     comb. t3: last sample of bank accepted this cycle
//   bank_free    out  1     comb. t4: bank ~wr_bank empty (with bypass)
// BEHAVIOUR
//   - Reset: wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, rd_bank=0, full=2'b00, ptr=0, len_q=0.
//   - len_q <= len on every cycle with state IDLE or READY; frozen during WORK/WAIT.
//   - accept = (state==WORK) & din_valid & ~full[wr_bank].
//   - On accept, at the next edge: wr_en=1, wr_addr={wr_bank,ptr}, wr_data=din.
//     Latency is 1 cycle; otherwise wr_en=0 and addr/data hold.
//   - On accept with ptr!=len_q: ptr++.
//   - On accept with ptr==len_q: ptr<=0, full[wr_bank]<=1, wr_bank<=~wr_bank.
//   - bank_done = accept & (ptr==len_q). It is combinational, so the FSM leaves WORK on the same
//     edge as the last accept; no extra sample is taken.
//   - bank_free = ~full[~wr_bank] | (rd_done & full[rd_bank] & rd_bank==~wr_bank).
//     The bypass lets a same-cycle reader release count as t4.
//   - rd_done with full[rd_bank]=1: full[rd_bank]<=0, rd_bank<=~rd_bank.
//     rd_done with full[rd_bank]=0 is ignored; no state change.
//   - Simultaneous bank_done and rd_done: both updates apply. They hit different banks because
//     accept requires ~full[wr_bank].
//   - Both banks full: accept is blocked and din is dropped (see overrun).
//     Writing resumes without a gap once rd_done frees wr_bank.
//   - state==IDLE: ptr<=0 (a partial bank is abandoned and not marked full); wr_bank unchanged.
//   - READY/WAIT: no writes; ptr holds.
//   - len_q=0: every accept completes a bank; wr_bank toggles per sample.
//   - ptr wraps only via the len_q compare; len_q=2**AW-1 uses the full bank.
//   - rst_n low at any time, mid-bank included: immediate clear to reset values; both banks empty.
// CONFIGURATION
//   OVERRUN_CNT_EN defined:
//     - adds output overrun_cnt [15:0], reset 0.
//     - +1 per cycle with din_valid & (state==WAIT | (state==WORK & full[wr_bank])).
//     - saturates at 16'hFFFF; cleared only by reset.
//   OVERRUN_CNT_EN undefined:
//     - port and counter absent; dropped samples are silent.
//     - all other behaviour identical.
// TESTING
//   1 len=3, state=WORK, 4 valid samples A..D
//     -> wr_addr 0,1,2,3 (bank 0) one cycle after each sample;
//     -> bank_done high with D; full=01, wr_bank=1; bank_free=1.
//   2 Two banks filled, no rd_done; state held WORK with valid samples
//     -> no wr_en; full=11; bank_free=0;
//     -> with OVERRUN_CNT_EN, overrun_cnt counts each sample.
//   3 full=01, wr_bank=1, last bank-1 sample in the same cycle as rd_done
//     -> bank_done=1, bank_free=1 (bypass); next cycle full=10, rd_bank=1, wr_bank=0.
//   4 len=7, 3 samples written, then state=IDLE, then WORK again
//     -> next write at wr_addr {0,3'd0}; full unchanged=00.
//   5 rst_n pulsed low mid-bank (ptr=5, full=01)
//     -> outputs at reset values asynchronously; first post-reset accept writes addr 0.
//   6 rd_done with full=00 -> rd_bank stays 0, full stays 00.
//     OVERRUN_CNT_EN preset to 16'hFFFE, 3 drops -> overrun_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pingpong_wr_ctrl.sv
// Write-side controller for a two-bank ping-pong buffer: bank write strobes, full tracking, t3/t4.
// Optional saturating drop counter enabled by defining OVERRUN_CNT_EN.
module pingpong_wr_ctrl #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    state,
   input  logic [AW-1:0] len,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   input  logic          rd_done,
   output logic          wr_en,
   output logic [AW:0]   wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          wr_bank,
   output logic          rd_bank,
   output logic [1:0]    full,
   output logic          bank_done,
   output logic          bank_free
`ifdef OVERRUN_CNT_EN
   ,
   output logic [15:0]   overrun_cnt
`endif
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReady = 2'd1,
      StWork  = 2'd2,
      StWait  = 2'd3
   } buf_state_e;

   buf_state_e st;
   assign st = buf_state_e'(state);

   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] len_q, len_d;
   logic          wr_en_q, wr_en_d;
   logic [AW:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [1:0]    full_q, full_d;

   logic accept;
   logic last;
   logic rd_rel;

   assign accept = (st == StWork) & din_valid & ~full_q[wr_bank_q];
   assign last   = (ptr_q == len_q);
   // A release only counts when the reader's bank is actually full.
   assign rd_rel = rd_done & full_q[rd_bank_q];

   assign bank_done = accept & last;
   assign bank_free = ~full_q[~wr_bank_q] | (rd_rel & (rd_bank_q == ~wr_bank_q));

   always_comb begin
      ptr_d     = ptr_q;
      len_d     = len_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;

      if ((st == StIdle) || (st == StReady)) begin
         len_d = len;
      end

      if (st == StIdle) begin
         ptr_d = '0;
      end else if (accept) begin
         wr_en_d   = 1'b1;
         wr_addr_d = {wr_bank_q, ptr_q};
         wr_data_d = din;
         if (last) begin
            ptr_d             = '0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
      end

      // Never collides with the set above: accept requires the write bank to be empty.
      if (rd_rel) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         len_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= 2'b00;
      end else begin
         ptr_q     <= ptr_d;
         len_q     <= len_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_bank = wr_bank_q;
   assign rd_bank = rd_bank_q;
   assign full    = full_q;

`ifdef OVERRUN_CNT_EN
   logic [15:0] ovr_q, ovr_d;
   logic        drop;

   assign drop = din_valid & ((st == StWait) | ((st == StWork) & full_q[wr_bank_q]));

   always_comb begin
      ovr_d = ovr_q;
      if (drop && (ovr_q != 16'hFFFF)) begin
         ovr_d = ovr_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_q <= '0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Randomized bench for pingpong_wr_ctrl against a bank-level behavioural model.
// Build with OVERRUN_CNT_EN defined to also check the drop counter.
module tb_pingpong_wr_ctrl;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int BANK = 1 << AW;

   localparam logic [1:0] IDLE = 2'd0, READY = 2'd1, WORK = 2'd2, WAIT = 2'd3;

   logic          clk;
   logic          rst_n;
   logic [1:0]    state;
   logic [AW-1:0] len;
   logic [DW-1:0] din;
   logic          din_valid;
   logic          rd_done;
   logic          wr_en;
   logic [AW:0]   wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_bank;
   logic          rd_bank;
   logic [1:0]    full;
   logic          bank_done;
   logic          bank_free;
`ifdef OVERRUN_CNT_EN
   logic [15:0]   overrun_cnt;
`endif

   pingpong_wr_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state),
      .len       (len),
      .din       (din),
      .din_valid (din_valid),
      .rd_done   (rd_done),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_bank   (wr_bank),
      .rd_bank   (rd_bank),
      .full      (full),
      .bank_done (bank_done),
      .bank_free (bank_free)
`ifdef OVERRUN_CNT_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: samples fill bank (wr) at position ptr; banks are a pair of flags.
   int        m_ptr, m_len, m_wr, m_rd, m_addr, m_ovr;
   bit [1:0]  m_full;
   bit        m_wen;
   logic [15:0] m_data;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_len = 0; m_wr = 0; m_rd = 0; m_addr = 0; m_ovr = 0;
      m_full = 2'b00; m_wen = 1'b0; m_data = '0;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input logic [1:0] st, input logic dv, input logic [DW-1:0] d,
                       input logic rd, input int ln);
      bit acc, lst, rel, exp_done, exp_free;
      int old_wr, old_rd;
      state = st; din_valid = dv; din = d; rd_done = rd; len = AW'(ln);
      #1;
      acc      = (st == WORK) && dv && !m_full[m_wr];
      lst      = (m_ptr == m_len);
      rel      = rd && m_full[m_rd];
      exp_done = acc && lst;
      exp_free = !m_full[1 - m_wr] || (rel && (m_rd != m_wr));
      check("bank_done", 32'(bank_done), 32'(exp_done));
      check("bank_free", 32'(bank_free), 32'(exp_free));

      old_wr = m_wr;
      old_rd = m_rd;
      if (dv && (st == WAIT || (st == WORK && m_full[old_wr])) && m_ovr < 65535) m_ovr++;
      m_wen = acc;
      if (acc) begin
         m_addr = old_wr * BANK + m_ptr;
         m_data = d;
      end
      if (st == IDLE) m_ptr = 0;
      else if (acc) begin
         if (lst) begin
            m_ptr = 0;
            m_full[old_wr] = 1'b1;
            m_wr = 1 - old_wr;
         end else begin
            m_ptr = m_ptr + 1;
         end
      end
      if (rel) begin
         m_full[old_rd] = 1'b0;
         m_rd = 1 - old_rd;
      end
      if (st == IDLE || st == READY) m_len = ln;

      @(posedge clk);
      #1;
      check("wr_en", 32'(wr_en), 32'(m_wen));
      check("wr_addr", 32'(wr_addr), 32'(m_addr));
      check("wr_data", 32'(wr_data), 32'(m_data));
      check("wr_bank", 32'(wr_bank), 32'(m_wr));
      check("rd_bank", 32'(rd_bank), 32'(m_rd));
      check("full", 32'(full), 32'(m_full));
`ifdef OVERRUN_CNT_EN
      check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
`endif
      @(negedge clk);
   endtask

   // Asserts reset between edges and checks the outputs clear before any clock arrives.
   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_wr_bank", 32'(wr_bank), 32'd0);
      check("rst_rd_bank", 32'(rd_bank), 32'd0);
      check("rst_full", 32'(full), 32'd0);
`ifdef OVERRUN_CNT_EN
      check("rst_overrun", 32'(overrun_cnt), 32'd0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int rand_len();
      int r = $urandom_range(0, 5);
      case (r)
         0: return 0;
         1: return 1;
         2: return 2;
         3: return 3;
         4: return BANK - 1;
         default: return $urandom_range(0, BANK - 1);
      endcase
   endfunction

   initial begin
      rst_n = 1'b1; state = IDLE; len = '0; din = '0; din_valid = 1'b0; rd_done = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      // rd_done with nothing full is ignored
      step(IDLE, 1'b0, 16'h0, 1'b1, 0);
      check("t6_rd_bank", 32'(rd_bank), 32'd0);
      check("t6_full", 32'(full), 32'd0);

      // Four samples into bank 0 with len=3
      step(READY, 1'b0, 16'h0, 1'b0, 3);
      for (int i = 0; i < 4; i++) begin
         step(WORK, 1'b1, 16'hA000 + 16'(i), 1'b0, 3);
         check("t1_addr", 32'(wr_addr), 32'(i));
      end
      check("t1_full", 32'(full), 32'h1);
      check("t1_wr_bank", 32'(wr_bank), 32'd1);

      // Last bank-1 sample coincides with the reader releasing bank 0
      for (int i = 0; i < 3; i++) step(WORK, 1'b1, 16'(i), 1'b0, 3);
      step(WORK, 1'b1, 16'hBEEF, 1'b1, 3);
      check("t3_full", 32'(full), 32'h2);
      check("t3_rd_bank", 32'(rd_bank), 32'd1);
      check("t3_wr_bank", 32'(wr_bank), 32'd0);

      // Fill bank 0 too, then keep pushing: everything dropped
      for (int i = 0; i < 4; i++) step(WORK, 1'b1, 16'(i), 1'b0, 3);
      for (int i = 0; i < 5; i++) step(WORK, 1'b1, 16'h5500 + 16'(i), 1'b0, 3);
      check("t2_full", 32'(full), 32'h3);
      check("t2_wr_en", 32'(wr_en), 32'd0);
      // Reader frees bank 1: writing resumes on the next sample
      step(WORK, 1'b1, 16'h1234, 1'b1, 3);
      step(WORK, 1'b1, 16'h4321, 1'b0, 3);
      check("t2_resume", 32'(wr_addr), 32'(BANK));

      // IDLE abandons a partial bank
      do_reset();
      step(READY, 1'b0, 16'h0, 1'b0, 7);
      for (int i = 0; i < 3; i++) step(WORK, 1'b1, 16'(i), 1'b0, 7);
      step(IDLE, 1'b0, 16'h0, 1'b0, 7);
      step(WORK, 1'b1, 16'h7777, 1'b0, 7);
      check("t4_addr", 32'(wr_addr), 32'd0);
      check("t4_full", 32'(full), 32'd0);

      // Async reset mid-bank (ptr=5, full=01)
      for (int i = 0; i < 7; i++) step(WORK, 1'b1, 16'(i), 1'b0, 7);
      for (int i = 0; i < 5; i++) step(WORK, 1'b1, 16'(i), 1'b0, 7);
      check("t5_full_pre", 32'(full), 32'h1);
      do_reset();
      step(WORK, 1'b1, 16'hCAFE, 1'b0, 7);
      check("t5_addr", 32'(wr_addr), 32'd0);
      check("t5_wr_en", 32'(wr_en), 32'd1);

      // Full-length bank boundary
      do_reset();
      step(READY, 1'b0, 16'h0, 1'b0, BANK - 1);
      for (int i = 0; i < BANK; i++) step(WORK, 1'b1, 16'(i), 1'b0, BANK - 1);
      check("fullbank_addr", 32'(wr_addr), 32'(BANK - 1));
      check("fullbank_full", 32'(full), 32'h1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         int r = $urandom_range(0, 19);
         logic [1:0] st;
         if (r < 2) st = IDLE;
         else if (r < 5) st = READY;
         else if (r < 17) st = WORK;
         else st = WAIT;
         if (n % 700 == 699) do_reset();
         step(st, 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 7) == 0),
              rand_len());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
